// File: rtl/bcd_pkg.sv
// Shared constants and types for the serial BCD-to-binary converter.
package bcd_pkg;

  localparam int BCD_DIGIT_W   = 4;
  localparam int BCD_MAX_DIGIT = 9;

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } conv_state_e;

  // Smallest width that holds every value of n decimal digits (10^n - 1).
  function automatic int min_bin_width(input int n);
    longint unsigned limit;
    int w;
    limit = 64'd1;
    for (int i = 0; i < n; i++) begin
      limit = limit * 64'd10;
    end
    w = 0;
    while ((64'd1 << w) < limit) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/mul10_add_digit.sv
// One Horner step: acc*10 + digit over W bits, flagging a non-decimal digit.
module mul10_add_digit
  import bcd_pkg::*;
#(
  parameter int W = 14
) (
  input  logic [W-1:0]           acc_i,
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [W-1:0]           result_o,
  output logic                   invalid_o
);

  // Shift-and-add keeps the multiply cheap; the sum wraps modulo 2^W by design.
  assign result_o  = (acc_i << 3) + (acc_i << 1) + W'(digit_i);
  assign invalid_o = (digit_i > BCD_DIGIT_W'(BCD_MAX_DIGIT));

endmodule

// File: rtl/bcd_to_binary_serial.sv
// Serial BCD-to-binary converter: one digit per clock, MSD first, start/busy/done handshake.
module bcd_to_binary_serial
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int OUT_WIDTH  = 14
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [BCD_DIGIT_W*NUM_DIGITS-1:0] bcd_in,
  output logic                              busy,
  output logic                              done,
  output logic [OUT_WIDTH-1:0]              binary_out,
  output logic                              error
);

  localparam int SR_W  = BCD_DIGIT_W * NUM_DIGITS;
  localparam int CNT_W = $clog2(NUM_DIGITS + 1);

  // A narrow OUT_WIDTH is legal: results then wrap silently with no overflow flag.
  if (OUT_WIDTH < min_bin_width(NUM_DIGITS)) begin : g_out_width_wraps
  end

  conv_state_e            state_q, state_d;
  logic [SR_W-1:0]        shreg_q, shreg_d;
  logic [OUT_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [OUT_WIDTH-1:0]   bin_q, bin_d;
  logic                   error_q, error_d;

  logic [OUT_WIDTH-1:0]   step_s;
  logic                   invalid_s;

  mul10_add_digit #(
    .W(OUT_WIDTH)
  ) u_step (
    .acc_i    (acc_q),
    .digit_i  (shreg_q[SR_W-1 -: BCD_DIGIT_W]),
    .result_o (step_s),
    .invalid_o(invalid_s)
  );

  // Next-state and datapath update for the conversion FSM.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bin_d   = bin_q;
    error_d = error_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d = bcd_in;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = CONVERT;
        end else begin
          state_d = IDLE;
        end
      end
      CONVERT: begin
        acc_d   = step_s;
        shreg_d = shreg_q << BCD_DIGIT_W;
        cnt_d   = cnt_q + CNT_W'(1);
        err_d   = err_q | invalid_s;
        if (cnt_q == CNT_W'(NUM_DIGITS - 1)) begin
          bin_d   = step_s;
          error_d = err_q | invalid_s;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = CONVERT;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bin_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bin_q   <= bin_d;
      error_q <= error_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign binary_out = bin_q;
  assign error      = error_q;

endmodule

// File: tb/tb_bcd_to_binary_serial.sv
// Scoreboard bench for bcd_to_binary_serial: a cycle model predicts busy/done and queued results.
module tb_bcd_to_binary_serial;

  localparam int N = 4;
  localparam int W = 14;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [4*N-1:0] bcd_in;
  logic           busy;
  logic           done;
  logic [W-1:0]   binary_out;
  logic           error;

  always #5 clk = ~clk;

  bcd_to_binary_serial #(
    .NUM_DIGITS(N),
    .OUT_WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bcd_in    (bcd_in),
    .busy      (busy),
    .done      (done),
    .binary_out(binary_out),
    .error     (error)
  );

  typedef struct packed {
    logic [W-1:0] val;
    logic         err;
  } res_t;

  int     checks = 0;
  int     errors = 0;
  res_t   sb_q[$];
  int     m_cnt = 0;
  logic   m_done = 1'b0;
  logic [W-1:0] m_bin = '0;
  logic   m_err = 1'b0;
  bit     chk_en = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference conversion written as plain decimal Horner evaluation.
  function automatic res_t ref_convert(input logic [4*N-1:0] b);
    res_t r;
    int   acc;
    int   d;
    acc = 0;
    r.err = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      d   = int'(b[4*i +: 4]);
      acc = (acc * 10 + d) % (1 << W);
      if (d > 9) r.err = 1'b1;
    end
    r.val = acc[W-1:0];
    return r;
  endfunction

  // Cycle model: tracks acceptance and completion at each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      m_done = 1'b0;
      if (rst === 1'b1) begin
        m_cnt = 0;
        sb_q.delete();
        m_bin = '0;
        m_err = 1'b0;
      end else if (m_cnt == 0) begin
        if (start === 1'b1) begin
          sb_q.push_back(ref_convert(bcd_in));
          m_cnt = N;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) m_done = 1'b1;
      end
    end
  end

  // Per-cycle comparison on the falling edge.
  initial begin
    res_t r;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check_eq("busy", busy, (m_cnt != 0));
        check_eq("done", done, m_done);
        if (done === 1'b1) begin
          check_eq("sb_nonempty", (sb_q.size() > 0), 1);
          if (sb_q.size() > 0) begin
            r = sb_q.pop_front();
            m_bin = r.val;
            m_err = r.err;
          end
        end
        check_eq("binary_out", binary_out, m_bin);
        check_eq("error", error, m_err);
      end
    end
  end

  task automatic pulse_start(input logic [4*N-1:0] v);
    bcd_in = v;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic [W-1:0] exp_val, input logic exp_err);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    check_eq({tag, "_done"}, done, 1'b1);
    check_eq({tag, "_val"}, binary_out, exp_val);
    check_eq({tag, "_err"}, error, exp_err);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    bcd_in = '0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    pulse_start(16'h2024);
    wait_done("y2024", 14'd2024, 1'b0);
    pulse_start(16'h9999);
    wait_done("max", 14'd9999, 1'b0);
    pulse_start(16'h0000);
    wait_done("zero", 14'd0, 1'b0);
    pulse_start(16'h12A4);
    wait_done("bad_digit", 14'd1304, 1'b1);
    pulse_start(16'h0059);
    wait_done("after_bad", 14'd59, 1'b0);

    // start held high: back-to-back conversions, later operand change mid-flight
    bcd_in = 16'h0001;
    start  = 1'b1;
    wait_done("held1", 14'd1, 1'b0);
    wait_done("held2", 14'd1, 1'b0);
    repeat (2) @(negedge clk);
    bcd_in = 16'h0777;
    wait_done("held3", 14'd1, 1'b0);
    wait_done("held777", 14'd777, 1'b0);
    start = 1'b0;
    repeat (3) @(negedge clk);

    // start pulse while busy must be ignored
    pulse_start(16'h0001);
    @(negedge clk);
    bcd_in = 16'h0777;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_done("ignored", 14'd1, 1'b0);
    repeat (6) @(negedge clk);

    // reset on the second CONVERT cycle aborts without a done pulse
    pulse_start(16'h1234);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_out", binary_out, 14'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    pulse_start(16'h0042);
    wait_done("after_rst", 14'd42, 1'b0);

    // rst and start together: rst wins
    rst    = 1'b1;
    bcd_in = 16'h0500;
    start  = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check_eq("rst_wins_busy", busy, 1'b0);
    repeat (6) @(negedge clk);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
